// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read-address arbiter with round-robin grant and per-requester
// outstanding-burst limits; read data is routed back by the MSB of the returned ID.
module axi_read_arbiter #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int MAX_OUTSTANDING    = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            s0_ARVALID,
  output logic                            s0_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s0_ARADDR,
  input  logic [7:0]                      s0_ARLEN,
  input  logic [2:0]                      s0_ARSIZE,
  input  logic [1:0]                      s0_ARBURST,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     s0_ARID,
  output logic                            s0_RVALID,
  input  logic                            s0_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s0_RDATA,
  output logic                            s0_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]     s0_RID,
  output logic [1:0]                      s0_RRESP,
  input  logic                            s1_ARVALID,
  output logic                            s1_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s1_ARADDR,
  input  logic [7:0]                      s1_ARLEN,
  input  logic [2:0]                      s1_ARSIZE,
  input  logic [1:0]                      s1_ARBURST,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     s1_ARID,
  output logic                            s1_RVALID,
  input  logic                            s1_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s1_RDATA,
  output logic                            s1_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]     s1_RID,
  output logic [1:0]                      s1_RRESP,
  output logic                            m_ARVALID,
  input  logic                            m_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_ARADDR,
  output logic [7:0]                      m_ARLEN,
  output logic [2:0]                      m_ARSIZE,
  output logic [1:0]                      m_ARBURST,
  output logic [C_M_AXI_ID_WIDTH:0]       m_ARID,
  input  logic                            m_RVALID,
  output logic                            m_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_RDATA,
  input  logic                            m_RLAST,
  input  logic [C_M_AXI_ID_WIDTH:0]       m_RID,
  input  logic [1:0]                      m_RRESP
);

  localparam int CW = 8;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]    state;
  logic          prio;
  logic [CW-1:0] cnt0, cnt1;
  logic          elig0, elig1, gnt0, gnt1;
  logic          r_sel, rlast_hs, inc0, inc1, dec0, dec1;

  assign elig0 = s0_ARVALID && (cnt0 < MAX_CNT);
  assign elig1 = s1_ARVALID && (cnt1 < MAX_CNT);

  // The priority holder wins a tie; the other requester wins only when alone.
  assign gnt0 = !ap_rst && (state == ST_IDLE) && elig0 && (!prio || !elig1);
  assign gnt1 = !ap_rst && (state == ST_IDLE) && elig1 && (prio || !elig0);

  assign s0_ARREADY = gnt0;
  assign s1_ARREADY = gnt1;
  assign m_ARVALID  = (state == ST_ISSUE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= ST_IDLE;
      prio      <= 1'b0;
      m_ARADDR  <= '0;
      m_ARLEN   <= '0;
      m_ARSIZE  <= '0;
      m_ARBURST <= '0;
      m_ARID    <= '0;
    end else if (state == ST_IDLE) begin
      if (gnt0) begin
        state     <= ST_ISSUE;
        prio      <= 1'b1;
        m_ARADDR  <= s0_ARADDR;
        m_ARLEN   <= s0_ARLEN;
        m_ARSIZE  <= s0_ARSIZE;
        m_ARBURST <= s0_ARBURST;
        m_ARID    <= {1'b0, s0_ARID};
      end else if (gnt1) begin
        state     <= ST_ISSUE;
        prio      <= 1'b0;
        m_ARADDR  <= s1_ARADDR;
        m_ARLEN   <= s1_ARLEN;
        m_ARSIZE  <= s1_ARSIZE;
        m_ARBURST <= s1_ARBURST;
        m_ARID    <= {1'b1, s1_ARID};
      end
    end else if (m_ARREADY) begin
      state <= ST_IDLE;
    end
  end

  // R path is purely combinational and independent of the AR state machine.
  assign r_sel     = m_RID[C_M_AXI_ID_WIDTH];
  assign s0_RVALID = m_RVALID && !r_sel;
  assign s1_RVALID = m_RVALID && r_sel;
  assign m_RREADY  = r_sel ? s1_RREADY : s0_RREADY;
  assign s0_RID    = m_RID[C_M_AXI_ID_WIDTH-1:0];
  assign s1_RID    = m_RID[C_M_AXI_ID_WIDTH-1:0];
  assign s0_RDATA  = m_RDATA;
  assign s1_RDATA  = m_RDATA;
  assign s0_RLAST  = m_RLAST;
  assign s1_RLAST  = m_RLAST;
  assign s0_RRESP  = m_RRESP;
  assign s1_RRESP  = m_RRESP;

  // A stray RLAST against an empty counter is dropped rather than wrapping.
  assign rlast_hs = m_RVALID && m_RREADY && m_RLAST;
  assign inc0     = s0_ARVALID && s0_ARREADY;
  assign inc1     = s1_ARVALID && s1_ARREADY;
  assign dec0     = rlast_hs && !r_sel && (cnt0 != '0);
  assign dec1     = rlast_hs && r_sel && (cnt1 != '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case ({inc0, dec0})
        2'b10:   cnt0 <= cnt0 + CW'(1);
        2'b01:   cnt0 <= cnt0 - CW'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({inc1, dec1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter built with an outstanding limit of 2 so the
// blocking boundary is reachable in a few grants.
module tb_axi_read_arbiter;

  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int DW  = 512;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic            s0_ARVALID, s0_ARREADY, s1_ARVALID, s1_ARREADY;
  logic [AW-1:0]   s0_ARADDR, s1_ARADDR, m_ARADDR;
  logic [7:0]      s0_ARLEN, s1_ARLEN, m_ARLEN;
  logic [2:0]      s0_ARSIZE, s1_ARSIZE, m_ARSIZE;
  logic [1:0]      s0_ARBURST, s1_ARBURST, m_ARBURST;
  logic [IDW-1:0]  s0_ARID, s1_ARID, s0_RID, s1_RID;
  logic            s0_RVALID, s0_RREADY, s1_RVALID, s1_RREADY;
  logic [DW-1:0]   s0_RDATA, s1_RDATA, m_RDATA;
  logic            s0_RLAST, s1_RLAST, m_RLAST;
  logic [1:0]      s0_RRESP, s1_RRESP, m_RRESP;
  logic            m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [IDW:0]    m_ARID, m_RID;

  int checks = 0;
  int errors = 0;

  axi_read_arbiter #(
    .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY), .s0_ARADDR(s0_ARADDR),
    .s0_ARLEN(s0_ARLEN), .s0_ARSIZE(s0_ARSIZE), .s0_ARBURST(s0_ARBURST), .s0_ARID(s0_ARID),
    .s0_RVALID(s0_RVALID), .s0_RREADY(s0_RREADY), .s0_RDATA(s0_RDATA),
    .s0_RLAST(s0_RLAST), .s0_RID(s0_RID), .s0_RRESP(s0_RRESP),
    .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY), .s1_ARADDR(s1_ARADDR),
    .s1_ARLEN(s1_ARLEN), .s1_ARSIZE(s1_ARSIZE), .s1_ARBURST(s1_ARBURST), .s1_ARID(s1_ARID),
    .s1_RVALID(s1_RVALID), .s1_RREADY(s1_RREADY), .s1_RDATA(s1_RDATA),
    .s1_RLAST(s1_RLAST), .s1_RID(s1_RID), .s1_RRESP(s1_RRESP),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
    .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_ARID(m_ARID),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA),
    .m_RLAST(m_RLAST), .m_RID(m_RID), .m_RRESP(m_RRESP)
  );

  always #5 ap_clk = ~ap_clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    s0_ARVALID = 0; s0_ARADDR = '0; s0_ARLEN = '0; s0_ARSIZE = '0; s0_ARBURST = '0; s0_ARID = '0;
    s1_ARVALID = 0; s1_ARADDR = '0; s1_ARLEN = '0; s1_ARSIZE = '0; s1_ARBURST = '0; s1_ARID = '0;
    s0_RREADY = 0; s1_RREADY = 0; m_ARREADY = 0;
    m_RVALID = 0; m_RDATA = '0; m_RLAST = 0; m_RID = '0; m_RRESP = '0;
    tick(); tick();
    ap_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    s0_ARVALID = 1'b1; s1_ARVALID = 1'b1;
    tick();
    checks++;
    if ({s0_ARREADY, s1_ARREADY, m_ARVALID} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ready_valid: got %b, expected 000", {s0_ARREADY, s1_ARREADY, m_ARVALID});
    end
    checks++;
    if (m_ARADDR !== 32'h0 || m_ARID !== 2'b00 || dut.cnt0 !== 8'd0 || dut.cnt1 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: addr=%h id=%b cnt0=%0d cnt1=%0d, expected all 0", m_ARADDR, m_ARID, dut.cnt0, dut.cnt1);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    s0_ARADDR = 32'h1000; s0_ARLEN = 8'd7; s0_ARID = 1'b1; s0_ARSIZE = 3'd6; s0_ARBURST = 2'b01;
    s0_ARVALID = 1'b1;
    #1;
    checks++;
    if (s0_ARREADY !== 1'b1 || m_ARVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant: arready=%b arvalid=%b, expected 1 0", s0_ARREADY, m_ARVALID);
    end
    tick();
    s0_ARVALID = 1'b0;
    checks++;
    if (m_ARVALID !== 1'b1 || m_ARID !== 2'b01 || m_ARLEN !== 8'd7 || m_ARADDR !== 32'h1000) begin
      errors++;
      $display("[TB] FAIL single_issue: v=%b id=%b len=%0d addr=%h, expected 1 01 7 1000", m_ARVALID, m_ARID, m_ARLEN, m_ARADDR);
    end
    checks++;
    if (dut.cnt0 !== 8'd1) begin
      errors++;
      $display("[TB] FAIL single_cnt_inc: got %0d, expected 1", dut.cnt0);
    end
    m_ARREADY = 1'b1;
    tick();
    m_ARREADY = 1'b0;
    checks++;
    if (m_ARVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_accept: arvalid=%b, expected 0", m_ARVALID);
    end
    s0_RREADY = 1'b1;
    m_RVALID = 1'b1; m_RID = 2'b01;
    for (int b = 0; b < 8; b++) begin
      m_RLAST = (b == 7);
      m_RDATA = DW'(b + 32'h100);
      tick();
      if (b == 6) begin
        checks++;
        if (dut.cnt0 !== 8'd1) begin
          errors++;
          $display("[TB] FAIL single_cnt_mid: got %0d, expected 1", dut.cnt0);
        end
      end
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0;
    checks++;
    if (dut.cnt0 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL single_cnt_dec: got %0d, expected 0", dut.cnt0);
    end
  endtask

  task automatic test_contention();
    logic exp_idx;
    do_reset();
    m_ARREADY = 1'b1;
    s0_ARVALID = 1'b1; s1_ARVALID = 1'b1;
    s0_ARADDR = 32'hA000; s1_ARADDR = 32'hB000;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_idx = g[0];
      checks++;
      if (s0_ARREADY !== !exp_idx || s1_ARREADY !== exp_idx) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: ready s0=%b s1=%b, expected requester %0d", g, s0_ARREADY, s1_ARREADY, exp_idx);
      end
      tick();
      checks++;
      if (m_ARVALID !== 1'b1 || m_ARID[1] !== exp_idx || {s0_ARREADY, s1_ARREADY} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL contention_issue%0d: v=%b idmsb=%b rdy=%b%b, expected 1 %0d 00", g, m_ARVALID, m_ARID[1], s0_ARREADY, s1_ARREADY, exp_idx);
      end
      tick();
    end
    checks++;
    if ({s0_ARREADY, s1_ARREADY, m_ARVALID} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL contention_both_full: got %b, expected 000", {s0_ARREADY, s1_ARREADY, m_ARVALID});
    end
    s0_ARVALID = 1'b0; s1_ARVALID = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_ARADDR = 32'h2040; s0_ARLEN = 8'd3; s0_ARID = 1'b0; s0_ARVALID = 1'b1;
    tick();
    s0_ARADDR = 32'hDEAD; s0_ARLEN = 8'd9;
    s1_ARVALID = 1'b1; s1_ARADDR = 32'h3000;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (m_ARVALID !== 1'b1 || m_ARADDR !== 32'h2040 || m_ARLEN !== 8'd3 || m_ARID !== 2'b00
          || s0_ARREADY !== 1'b0 || s1_ARREADY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold%0d: v=%b addr=%h len=%0d id=%b rdy=%b%b, expected 1 2040 3 00 00",
                 c, m_ARVALID, m_ARADDR, m_ARLEN, m_ARID, s0_ARREADY, s1_ARREADY);
      end
      tick();
    end
    s0_ARVALID = 1'b0; s1_ARVALID = 1'b0;
    m_ARREADY = 1'b1;
    tick();
    m_ARREADY = 1'b0;
    checks++;
    if (m_ARVALID !== 1'b0 || dut.cnt0 !== 8'd1 || dut.cnt1 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL backpressure_release: v=%b cnt0=%0d cnt1=%0d, expected 0 1 0", m_ARVALID, dut.cnt0, dut.cnt1);
    end
  endtask

  task automatic test_limit();
    do_reset();
    m_ARREADY = 1'b1;
    s0_ARVALID = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (s0_ARREADY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL limit_fill%0d: s0_arready=%b, expected 1", g, s0_ARREADY);
      end
      tick(); tick();
    end
    checks++;
    if (s0_ARREADY !== 1'b0 || m_ARVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limit_blocked: rdy=%b v=%b, expected 0 0", s0_ARREADY, m_ARVALID);
    end
    s1_ARVALID = 1'b1;
    #1;
    checks++;
    if (s1_ARREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_s1_first: s1_arready=%b, expected 1", s1_ARREADY);
    end
    tick(); tick();
    // priority now sits with s0, yet the blocked s0 must not starve s1
    checks++;
    if (s0_ARREADY !== 1'b0 || s1_ARREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_s1_over_blocked: rdy s0=%b s1=%b, expected 0 1", s0_ARREADY, s1_ARREADY);
    end
    tick(); tick();
    s1_ARVALID = 1'b0;
    s0_RREADY = 1'b1; m_RVALID = 1'b1; m_RLAST = 1'b1; m_RID = 2'b00;
    tick();
    m_RVALID = 1'b0; m_RLAST = 1'b0;
    #1;
    checks++;
    if (dut.cnt0 !== 8'd1 || s0_ARREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_unblock: cnt0=%0d rdy=%b, expected 1 1", dut.cnt0, s0_ARREADY);
    end
    // a grant and an RLAST for s0 in the same cycle leave the count unchanged
    m_RVALID = 1'b1; m_RLAST = 1'b1;
    tick();
    m_RVALID = 1'b0; m_RLAST = 1'b0; s0_ARVALID = 1'b0;
    checks++;
    if (dut.cnt0 !== 8'd1 || m_ARID[1] !== 1'b0 || m_ARVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_coincide: cnt0=%0d idmsb=%b v=%b, expected 1 0 1", dut.cnt0, m_ARID[1], m_ARVALID);
    end
    tick();
  endtask

  task automatic test_routing();
    do_reset();
    m_RVALID = 1'b1; m_RID = 2'b10; m_RDATA = {16{32'hCAFE_0001}}; m_RRESP = 2'b10; m_RLAST = 1'b1;
    s0_RREADY = 1'b1; s1_RREADY = 1'b0;
    #1;
    checks++;
    if (s1_RVALID !== 1'b1 || s0_RVALID !== 1'b0 || m_RREADY !== 1'b0 || s1_RID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL route_s1: s1v=%b s0v=%b rready=%b s1rid=%b, expected 1 0 0 0", s1_RVALID, s0_RVALID, m_RREADY, s1_RID);
    end
    checks++;
    if (s0_RDATA !== {16{32'hCAFE_0001}} || s1_RDATA !== {16{32'hCAFE_0001}} || s0_RRESP !== 2'b10 || s1_RLAST !== 1'b1) begin
      errors++;
      $display("[TB] FAIL route_broadcast: s0_rresp=%b s1_rlast=%b, expected 10 1", s0_RRESP, s1_RLAST);
    end
    s1_RREADY = 1'b1;
    tick();
    checks++;
    if (m_RREADY !== 1'b1 || dut.cnt1 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL route_underflow: rready=%b cnt1=%0d, expected 1 0", m_RREADY, dut.cnt1);
    end
    m_RID = 2'b01; s0_RREADY = 1'b0;
    #1;
    checks++;
    if (s0_RVALID !== 1'b1 || s1_RVALID !== 1'b0 || s0_RID !== 1'b1 || m_RREADY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL route_s0: s0v=%b s1v=%b s0rid=%b rready=%b, expected 1 0 1 0", s0_RVALID, s1_RVALID, s0_RID, m_RREADY);
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    s1_ARVALID = 1'b1; s1_ARADDR = 32'h4000; s1_ARID = 1'b1;
    tick();
    s1_ARVALID = 1'b0;
    checks++;
    if (m_ARVALID !== 1'b1 || m_ARID !== 2'b11 || dut.cnt1 !== 8'd1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: v=%b id=%b cnt1=%0d, expected 1 11 1", m_ARVALID, m_ARID, dut.cnt1);
    end
    ap_rst = 1'b1;
    m_RVALID = 1'b1; m_RID = 2'b10;
    #1;
    checks++;
    if (m_ARVALID !== 1'b0 || s1_RVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_async: arvalid=%b s1_rvalid=%b, expected 0 1", m_ARVALID, s1_RVALID);
    end
    m_RVALID = 1'b0;
    tick();
    ap_rst = 1'b0;
    tick();
    checks++;
    if (m_ARVALID !== 1'b0 || dut.cnt0 !== 8'd0 || dut.cnt1 !== 8'd0 || m_ARADDR !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_after: v=%b cnt0=%0d cnt1=%0d addr=%h, expected 0 0 0 0", m_ARVALID, dut.cnt0, dut.cnt1, m_ARADDR);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_limit();
    test_routing();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
